// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the SubBytes engine:
//   STATE_W     - width of an AES state in bits (128)
//   NUM_BYTES   - bytes per state (16)
//   state_t     - engine FSM state encoding (IDLE / BUSY / DONE)
//   lanes_legal - the set of supported LANES values (1, 2, 4, 8, 16)
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = STATE_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // LANES must divide the 16-byte state into power-of-two groups.
    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// ---------------------------------------------------------------------------
// sub_bytes_engine_if
// Groups the input (valid/ready/state/inv) and output (valid/ready/state)
// handshakes of sub_bytes_engine.
//   master : the producer/consumer side (drives in_*, out_ready)
//   slave  : the engine side (drives in_ready, out_valid, out_state)
// ---------------------------------------------------------------------------
interface sub_bytes_engine_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/sbox_lane.sv
// ---------------------------------------------------------------------------
// sbox_lane
// Purely combinational AES S-box for one byte.
//   i_byte : byte to substitute
//   i_inv  : 1 = inverse S-box, 0 = forward S-box
//   o_byte : substituted byte
// Macro SUB_BYTES_FWD_EN: when defined both tables exist and i_inv selects;
// when undefined only the inverse table is built and i_inv is ignored.
// ---------------------------------------------------------------------------
module sbox_lane (
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

    // Tables are stored entry 0 first, so entry x sits at bits
    // [2047-8x -: 8].
    localparam logic [2047:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] w_base;
    logic [7:0]  w_inv_byte;

    assign w_base     = 11'd2047 - {i_byte, 3'b000};
    assign w_inv_byte = INV_TBL[w_base -: 8];

`ifdef SUB_BYTES_FWD_EN
    localparam logic [2047:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] w_fwd_byte;

    assign w_fwd_byte = FWD_TBL[w_base -: 8];
    assign o_byte     = i_inv ? w_inv_byte : w_fwd_byte;
`else
    // Inverse-only build: the mode input is kept for a stable port list.
    logic w_unused_inv;

    assign w_unused_inv = i_inv;
    assign o_byte       = w_inv_byte;
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// sub_bytes_engine
// Applies the AES S-box to every byte of a 128-bit state, LANES bytes per
// clock, behind valid/ready handshakes on input and output.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   in_valid  / in_ready  / in_state / in_inv : input handshake + state + mode
//   out_valid / out_ready / out_state         : output handshake + result
// Parameter LANES: bytes per cycle, one of 1, 2, 4, 8, 16.
// Macro SUB_BYTES_FWD_EN: enables the forward S-box; without it the engine
// always applies the inverse S-box.
// Latency: out_valid rises 16/LANES cycles after the accepting edge.
// ---------------------------------------------------------------------------
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    localparam int GROUPS  = NUM_BYTES / LANES;
    localparam int GROUP_W = LANES * 8;
    localparam int CNT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    generate
        if (!lanes_legal(LANES)) begin : g_lanes_check
            $error("sub_bytes_engine: LANES=%0d is not one of 1, 2, 4, 8, 16", LANES);
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [STATE_W-1:0]   r_work;
    logic                 r_inv;
    logic                 w_accept;
    logic                 w_busy;
    logic [6:0]           w_base;
    logic [GROUP_W-1:0]   w_cur_group;
    logic [GROUP_W-1:0]   w_sub_group;

    // Bit offset of the group being substituted this cycle. Group widths
    // are powers of two, so the offset is the counter shifted left.
    generate
        if (GROUPS == 1) begin : g_single
            assign w_base = 7'd0;
        end else begin : g_multi
            localparam int GSHIFT = $clog2(GROUP_W);
            assign w_base = {r_cnt, {GSHIFT{1'b0}}};
        end
    endgenerate

    assign w_cur_group = r_work[w_base +: GROUP_W];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            sbox_lane u_sbox (
                .i_byte (w_cur_group[gi*8 +: 8]),
                .i_inv  (r_inv),
                .o_byte (w_sub_group[gi*8 +: 8])
            );
        end
    endgenerate

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_work <= in_state;
                r_inv  <= in_inv;
            end else if (w_busy) begin
                r_work[w_base +: GROUP_W] <= w_sub_group;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_state = r_work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_engine
// Drives three engines (LANES = 1, 4, 16) with the same directed stimulus
// and checks handshake timing and substituted states against hand-computed
// S-box values. Expectations follow the SUB_BYTES_FWD_EN build option.
// ---------------------------------------------------------------------------
module tb_sub_bytes_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         d_valid;
    logic         d_inv;
    logic         d_oready;
    logic [127:0] d_state;

    int n_total = 0;
    int n_bad   = 0;

`ifdef SUB_BYTES_FWD_EN
    localparam logic [127:0] EXP_A = {16{8'h63}};
    localparam logic [127:0] EXP_C = {{15{8'h55}}, 8'hED};
`else
    localparam logic [127:0] EXP_A = {16{8'h52}};
    localparam logic [127:0] EXP_C = {{15{8'h53}}, 8'h50};
`endif
    localparam logic [127:0] EXP_B = 128'h0;
    localparam logic [127:0] EXP_D = {{15{8'h53}}, 8'h50};
    localparam logic [127:0] EXP_E = {16{8'h52}};
    localparam logic [127:0] VEC_C = {{15{8'hED}}, 8'h53};

    sub_bytes_engine_if bus1 ();
    sub_bytes_engine_if bus4 ();
    sub_bytes_engine_if bus16 ();

    assign bus1.in_valid   = d_valid;
    assign bus1.in_state   = d_state;
    assign bus1.in_inv     = d_inv;
    assign bus1.out_ready  = d_oready;
    assign bus4.in_valid   = d_valid;
    assign bus4.in_state   = d_state;
    assign bus4.in_inv     = d_inv;
    assign bus4.out_ready  = d_oready;
    assign bus16.in_valid  = d_valid;
    assign bus16.in_state  = d_state;
    assign bus16.in_inv    = d_inv;
    assign bus16.out_ready = d_oready;

    sub_bytes_engine #(.LANES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(bus1.in_valid), .in_ready(bus1.in_ready),
        .in_state(bus1.in_state), .in_inv(bus1.in_inv),
        .out_valid(bus1.out_valid), .out_ready(bus1.out_ready),
        .out_state(bus1.out_state)
    );

    sub_bytes_engine #(.LANES(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(bus4.in_valid), .in_ready(bus4.in_ready),
        .in_state(bus4.in_state), .in_inv(bus4.in_inv),
        .out_valid(bus4.out_valid), .out_ready(bus4.out_ready),
        .out_state(bus4.out_state)
    );

    sub_bytes_engine #(.LANES(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(bus16.in_valid), .in_ready(bus16.in_ready),
        .in_state(bus16.in_state), .in_inv(bus16.in_inv),
        .out_valid(bus16.out_valid), .out_ready(bus16.out_ready),
        .out_state(bus16.out_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // k = cycles after the accepting edge; n = 16/LANES.
    task automatic check_dut(input string nm, input int n, input int k,
                             input logic ov, input logic ir,
                             input logic [127:0] os, input logic [127:0] exp);
        chk($sformatf("%s_out_valid_k%0d", nm, k), 128'(ov), 128'(k == n));
        chk($sformatf("%s_in_ready_k%0d", nm, k), 128'(ir), 128'(k > n));
        if (k == n)
            chk($sformatf("%s_out_state", nm), os, exp);
    endtask

    task automatic check_all(input string tag, input logic ov, input logic ir,
                             input logic [127:0] os);
        chk({tag, "_l1_valid"},  128'(bus1.out_valid),  128'(ov));
        chk({tag, "_l1_ready"},  128'(bus1.in_ready),   128'(ir));
        chk({tag, "_l1_state"},  bus1.out_state,        os);
        chk({tag, "_l4_valid"},  128'(bus4.out_valid),  128'(ov));
        chk({tag, "_l4_ready"},  128'(bus4.in_ready),   128'(ir));
        chk({tag, "_l4_state"},  bus4.out_state,        os);
        chk({tag, "_l16_valid"}, 128'(bus16.out_valid), 128'(ov));
        chk({tag, "_l16_ready"}, 128'(bus16.in_ready),  128'(ir));
        chk({tag, "_l16_state"}, bus16.out_state,       os);
    endtask

    // One accepted state, out_ready held high; optionally disturb the
    // inputs after acceptance to show they are ignored.
    task automatic txn(input string nm, input logic [127:0] st, input logic inv,
                       input logic [127:0] exp, input bit garble);
        d_state  = st;
        d_inv    = inv;
        d_oready = 1'b1;
        d_valid  = 1'b1;
        tick;
        d_valid = 1'b0;
        if (garble) begin
            d_state = ~st;
            d_inv   = ~inv;
        end
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) tick;
            check_dut({nm, "_l1"},  16, k, bus1.out_valid,  bus1.in_ready,  bus1.out_state,  exp);
            check_dut({nm, "_l4"},  4,  k, bus4.out_valid,  bus4.in_ready,  bus4.out_state,  exp);
            check_dut({nm, "_l16"}, 1,  k, bus16.out_valid, bus16.in_ready, bus16.out_state, exp);
        end
        $display("txn %s: state=%h inv=%0d expected=%h", nm, st, inv, exp);
    endtask

    initial begin
        reset    = 1'b1;
        d_valid  = 1'b0;
        d_inv    = 1'b0;
        d_oready = 1'b0;
        d_state  = '0;
        tick;
        tick;
        check_all("reset", 1'b0, 1'b1, 128'h0);
        reset = 1'b0;
        tick;
        check_all("post_reset", 1'b0, 1'b1, 128'h0);
        $display("txn reset: idle after reset");

        txn("zeros_fwd", 128'h0, 1'b0, EXP_A, 1'b0);
        txn("all63_inv", {16{8'h63}}, 1'b1, EXP_B, 1'b0);
        txn("b53_fwd", VEC_C, 1'b0, EXP_C, 1'b0);
        txn("b53_inv_garble", VEC_C, 1'b1, EXP_D, 1'b1);

        // Backpressure: hold out_ready low in DONE, poke in_valid meanwhile.
        d_state  = 128'h0;
        d_inv    = 1'b1;
        d_oready = 1'b0;
        d_valid  = 1'b1;
        tick;
        d_valid = 1'b0;
        repeat (16) tick;
        for (int h = 0; h < 5; h++) begin
            check_all($sformatf("hold%0d", h), 1'b1, 1'b0, EXP_E);
            if (h == 0) begin
                d_valid = 1'b1;
                d_state = {16{8'hA5}};
                d_inv   = 1'b0;
            end
            tick;
        end
        d_valid = 1'b0;
        check_all("hold_end", 1'b1, 1'b0, EXP_E);
        d_oready = 1'b1;
        tick;
        check_all("hold_release", 1'b0, 1'b1, EXP_E);
        $display("txn hold: out_ready low for 5 cycles in DONE");

        // Reset during the second BUSY cycle.
        d_state  = {16{8'h63}};
        d_inv    = 1'b1;
        d_oready = 1'b1;
        d_valid  = 1'b1;
        tick;
        d_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_all("mid_reset", 1'b0, 1'b1, 128'h0);
        for (int c = 0; c < 20; c++) begin
            tick;
            chk($sformatf("mid_reset_l1_valid_c%0d", c), 128'(bus1.out_valid), 128'(1'b0));
            chk($sformatf("mid_reset_l4_valid_c%0d", c), 128'(bus4.out_valid), 128'(1'b0));
            chk($sformatf("mid_reset_l4_ready_c%0d", c), 128'(bus4.in_ready), 128'(1'b1));
        end
        $display("txn mid_reset: operation discarded");

        // Reset wins over a simultaneous handshake.
        d_state = {16{8'h11}};
        d_valid = 1'b1;
        reset   = 1'b1;
        tick;
        d_valid = 1'b0;
        reset   = 1'b0;
        check_all("reset_prio", 1'b0, 1'b1, 128'h0);
        tick;
        check_all("reset_prio_next", 1'b0, 1'b1, 128'h0);
        $display("txn reset_prio: handshake ignored under reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: number of bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the input state is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the engine can accept a state.
REQ-006 SHALL have port in_state, input, 128 bits: the state to substitute; byte i is bits [8i+7:8i].
REQ-007 SHALL have port in_inv, input, 1 bit: mode, 1 for inverse S-box and 0 for forward S-box.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_state, output, 128 bits: the substituted state.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both from registered state with no combinational in-to-out paths.
REQ-013 SHALL, in IDLE, on in_valid=1 (handshake), capture in_state and in_inv, clear the byte counter and go to BUSY.
REQ-014 SHALL, in BUSY, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with their S-box values each cycle, in ascending byte order.
REQ-015 SHALL leave all other bytes untouched during a BUSY cycle.
REQ-016 SHALL go to DONE after exactly 16/LANES BUSY cycles; out_valid SHALL rise 16/LANES cycles after the accepting edge.
REQ-017 SHALL, in DONE, hold out_state stable until out_valid and out_ready are both 1, then go to IDLE; in_ready returns the next cycle, so the minimum initiation interval is 16/LANES+2 cycles.
REQ-018 SHALL ignore in_valid, in_state and in_inv outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-019 SHALL apply the in_inv value captured at acceptance to the whole state; changing in_inv mid-operation has no effect.
REQ-020 SHALL wrap the byte counter to 0 on entering DONE; for LANES=16 the counter is a constant 0 and BUSY lasts one cycle.
REQ-021 SHALL implement the forward and inverse S-boxes as the FIPS-197 tables, e.g. fwd(0x00)=0x63, inv(0x63)=0x00, inv(0x00)=0x52.
REQ-022 SHALL make any other LANES value an elaboration-time error.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, go to IDLE, clear the working register and counter, and drive in_ready=1, out_valid=0 and out_state=0 from the next cycle.
REQ-024 SHALL, if reset occurs in BUSY or DONE, discard the operation in progress and produce no out_valid for it.
REQ-025 SHALL let reset take priority over any simultaneous handshake.

Configuration
REQ-026 SHALL, with SUB_BYTES_FWD_EN defined, implement both S-box tables and select between them per in_inv.
REQ-027 SHALL, without SUB_BYTES_FWD_EN, compile out the forward table, ignore in_inv and always apply the inverse S-box, while keeping the port list unchanged.

Structure
REQ-028 SHALL take the FSM state typedef, the legal LANES set and the state width constant (128) from the shared package aes_pkg.
REQ-029 SHALL instantiate sub-module sbox_lane (8-bit in, inv select, 8-bit out, purely combinational) LANES times, with the forward table guarded by SUB_BYTES_FWD_EN.

Verification
REQ-030 SHALL cover: LANES=4, in_state=all 0x00, in_inv=0 -> out_state=all 0x63, out_valid 4 cycles after acceptance.
REQ-031 SHALL cover: LANES=1, in_state=all 0x63, in_inv=1 -> out_state=all 0x00 after 16 cycles; in_ready=0 throughout.
REQ-032 SHALL cover: LANES=16, byte0=0x53 with all other bytes 0xED, in_inv=0 then 1 -> byte0=0xED/others=0x55, then byte0=0x50/others=0x53, each one cycle after acceptance.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_state stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover: reset asserted in the 2nd BUSY cycle -> out_valid never rises for that state, in_ready=1 and out_state=0 next cycle.
REQ-035 SHALL cover: build without SUB_BYTES_FWD_EN, in_state=all 0x00, in_inv=0 -> out_state=all 0x52.
